ser_uart_rx: RTL
================

Name: ser_uart_rx

Overview:
- 8N1 UART receiver for the ser0/ser1/ser2 board serial lines (ser*_rx pins), one instance per line inside the system wrapper.
- Counterpart to the existing ser*_tx transmit path.
- Synchronises and optionally inverts the raw pin, then recovers bytes by mid-bit sampling against a runtime baud divisor.
- Delivers bytes through a small FIFO on a valid/ready stream, with sticky error flags for the register file.

Parameters:
- INVERT, 0, 1 = invert rx pin after synchronisation (use for lines behind the inverting level translator).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  in  1  single clock domain for all logic.
- resetn  in  1  asynchronous active-low reset.
- rx_pin  in  1  raw asynchronous serial input.
- cfg_div  in  DIV_W  clk cycles per bit; values below 4 are treated as 4; sampled only in IDLE.
- m_data  out  8  received byte at the FIFO head.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head byte when m_valid & m_ready.
- frm_err  out  1  sticky: stop bit sampled low.
- ovf_err  out  1  sticky: good byte dropped because the FIFO was full.
- err_clr  in  1  one-cycle pulse; clears frm_err and ovf_err.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (all asynchronous on resetn low):
  - m_valid=0, m_data=0, frm_err=0, ovf_err=0, busy=0.
  - FIFO empty, state IDLE.
  - Synchroniser flops preset to idle-high, after INVERT is applied.
- Input path:
  - 2-flop synchroniser on rx_pin, then an optional INVERT.
  - The result is `rxs`; idle level of `rxs` is 1.
- Divisor: `div` is latched from cfg_div on leaving IDLE and held constant for the whole frame.
- Bit timer: counts `div` cycles; a sample is taken when the timer reaches its terminal count.
- State machine:
  - IDLE: on the first cycle with rxs=0, latch `div`, load the timer for floor(div/2) cycles, go to START.
  - START: at the half-bit sample:
    - rxs=0: load the timer for `div`, clear the bit index, go to DATA.
    - rxs=1: false start (glitch); go to IDLE with no error.
  - DATA: 8 samples spaced `div` apart, LSB first, shifted into a shift register. After the 8th sample go to STOP.
  - STOP: one sample `div` after the last data bit.
    - rxs=1: push the byte, go to IDLE.
    - rxs=0: set frm_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents re-triggering during a break condition.
- Push timing and overflow:
  - The push happens on the clock edge ending the stop-sample cycle.
  - If the FIFO was empty, m_valid=1 and m_data are valid from the next cycle.
  - If the FIFO is full at push time, the byte is dropped, ovf_err is set and the contents are unchanged.
  - A pop in the same cycle as a push to a full FIFO counts as freeing space: the push succeeds and ovf_err is not set.
- FIFO:
  - First-word-fall-through: m_data is always the head entry.
  - Pop on m_valid & m_ready; simultaneous push and pop keeps the count unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Sticky flags:
  - Set has priority over err_clr in the same cycle.
  - err_clr does not affect the FIFO or the state machine.
- cfg_div changes mid-frame have no effect until the next IDLE.
- Reset mid-frame: partial byte discarded; after release the block waits in IDLE for a fresh falling edge. Because the synchroniser presets high, a line that is already low at release registers as a falling edge.
- Nominal timing from the start edge at the pin: sample k (k=0 start, 1..8 data, 9 stop) occurs at 2+floor(div/2)+k*div cycles ±1.

Test Plan:
- div=16, INVERT=0, send 0xA5 with 16-cycle bits, m_ready=1 -> single m_valid pulse with m_data=0xA5; m_valid first high 2+8+9*16+1=155 cycles after the start edge at the pin (±1); no error flags.
- div=16, rx_pin low for 5 cycles then high -> state returns to IDLE, no push, frm_err=0, busy drops within 11 cycles.
- div=16, send 0x3C with the stop bit held low for 3 bit times -> frm_err=1, no byte pushed, busy stays high until the line returns high; a following 0x55 is received correctly; an err_clr pulse then clears frm_err.
- FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 -> 4 entries held, ovf_err=1 after the 5th; with m_ready=1, output is 0x01,0x02,0x03,0x04, then m_valid=0.
- INVERT=1, div=4, drive the inverted waveform of 0xF0 -> m_data=0xF0; cfg_div changed to 100 mid-frame does not corrupt the byte.
- Assert resetn low during the 4th data bit of 0xAA, release, then send 0x81 -> only 0x81 is delivered; all outputs were 0 during reset.

Source files
------------

// File: rtl/ser_uart_rx.sv
// 8N1 UART receiver: synchronised (optionally inverted) pin, mid-bit sampling against a
// runtime divisor, first-word-fall-through output FIFO and sticky error flags.
module ser_uart_rx #(
  parameter bit INVERT     = 1'b0,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_pin,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frm_err,
  output logic             ovf_err,
  input  logic             err_clr,
  output logic             busy
);
  localparam int   AW       = $clog2(FIFO_DEPTH);
  localparam logic SYNC_RST = INVERT ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic             r_sync1, r_sync2;
  logic             w_rxs;
  logic [DIV_W-1:0] w_div_in;
  state_t           r_state;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_busy, r_frm, r_ovf;
  logic             w_tick, w_push, w_frm_set, w_ovf_set;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [AW:0]      w_count;
  logic             w_full, w_empty, w_pop, w_wr;

  // Presets make the synchronised line look idle-high out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs    = r_sync2 ^ INVERT;
  assign w_div_in = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
  assign w_tick   = (r_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_rxs) begin
          r_div   <= w_div_in;
          r_cnt   <= (w_div_in >> 1) - DIV_W'(1);
          r_state <= S_START;
          r_busy  <= 1'b1;
        end
        S_START: if (w_tick) begin
          if (!w_rxs) begin
            r_cnt   <= r_div - DIV_W'(1);
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end else r_cnt <= r_cnt - DIV_W'(1);
        S_DATA: if (w_tick) begin
          r_shift <= {w_rxs, r_shift[7:1]};
          r_cnt   <= r_div - DIV_W'(1);
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= S_STOP;
        end else r_cnt <= r_cnt - DIV_W'(1);
        S_STOP: if (w_tick) begin
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else r_state <= S_BREAK;
        end else r_cnt <= r_cnt - DIV_W'(1);
        S_BREAK: if (w_rxs) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_push    = (r_state == S_STOP) && w_tick && w_rxs;
  assign w_frm_set = (r_state == S_STOP) && w_tick && !w_rxs;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = !w_empty && m_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= r_shift;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frm <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_frm <= w_frm_set | (r_frm & ~err_clr);
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
    end
  end

  assign m_data  = r_mem[r_rptr[AW-1:0]];
  assign m_valid = !w_empty;
  assign frm_err = r_frm;
  assign ovf_err = r_ovf;
  assign busy    = r_busy;
endmodule
